// File: rtl/msg_frame_tx.sv
// Message framer for the 9-bit UART transmitter: START, byte count, payload, END.
// Each symbol is loaded once tx_empty is seen and then waits for the UART to accept it.
module msg_frame_tx #(
  parameter int         DATAMAXBYTES = 10,
  parameter logic [7:0] SP_START     = 8'h7E,
  parameter logic [7:0] SP_END       = 8'h7D,
  parameter int         ACK_TIMEOUT  = 100
) (
  input  logic       ct_rxclk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       send,
  input  logic [7:0] send_len,
  input  logic       tx_empty,
  output logic [8:0] tx_data,
  output logic       ld_tx_data,
  output logic       tx_enable,
  output logic       busy,
  output logic       done,
  output logic       len_clamped,
  output logic       ack_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BCNT  = 3'd2;
  localparam logic [2:0] S_BODY  = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  localparam logic [0:0] P_WAIT_EMPTY  = 1'b0;
  localparam logic [0:0] P_WAIT_ACCEPT = 1'b1;

  localparam int         CW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [7:0] MAX_LEN = 8'(DATAMAXBYTES);
  localparam logic [4:0] DEPTH   = 5'(DATAMAXBYTES);

  logic [7:0]    pbuf [DATAMAXBYTES];
  logic [2:0]    state;
  logic [0:0]    phase;
  logic [7:0]    len;
  logic [3:0]    idx;
  logic [CW-1:0] acc_cnt;
  logic [8:0]    sym;
  logic          last_byte;
  logic          len_over;
  logic          buf_wr;

  assign len_over  = (send_len > MAX_LEN);
  assign last_byte = ({4'b0000, idx} == (len - 8'd1));
  assign buf_wr    = wr_en && !busy && ({1'b0, wr_addr} < DEPTH);

  // Payload is frozen while a frame is in flight so the body cannot tear.
  always_ff @(posedge ct_rxclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DATAMAXBYTES; i++) pbuf[i] <= 8'h00;
    end else if (buf_wr) begin
      pbuf[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    sym = 9'h000;
    case (state)
      S_START: sym = {1'b1, SP_START};
      S_BCNT:  sym = {1'b0, len};
      S_BODY:  sym = {1'b0, pbuf[idx]};
      S_END:   sym = {1'b1, SP_END};
      default: sym = 9'h000;
    endcase
  end

  always_ff @(posedge ct_rxclk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      phase       <= P_WAIT_EMPTY;
      len         <= 8'h00;
      idx         <= 4'h0;
      acc_cnt     <= '0;
      tx_data     <= 9'h000;
      ld_tx_data  <= 1'b0;
      tx_enable   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      len_clamped <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      ld_tx_data <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (send) begin
            len         <= len_over ? MAX_LEN : send_len;
            len_clamped <= len_over;
            ack_timeout <= 1'b0;
            busy        <= 1'b1;
            tx_enable   <= 1'b1;
            state       <= S_START;
            phase       <= P_WAIT_EMPTY;
            idx         <= 4'h0;
            acc_cnt     <= '0;
          end
        end
        S_START, S_BCNT, S_BODY, S_END: begin
          if (phase == P_WAIT_EMPTY) begin
            if (tx_empty) begin
              tx_data    <= sym;
              ld_tx_data <= 1'b1;
              phase      <= P_WAIT_ACCEPT;
              acc_cnt    <= '0;
            end
          end else if (!tx_empty) begin
            // UART took the symbol: step to the next one.
            phase <= P_WAIT_EMPTY;
            case (state)
              S_START: state <= S_BCNT;
              S_BCNT: begin
                state <= (len == 8'h00) ? S_END : S_BODY;
                idx   <= 4'h0;
              end
              S_BODY: begin
                if (last_byte) state <= S_END;
                else           idx   <= idx + 4'h1;
              end
              default: begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                tx_enable <= 1'b0;
                done      <= 1'b1;
              end
            endcase
          end else if (acc_cnt == CW'(ACK_TIMEOUT - 1)) begin
            state       <= S_IDLE;
            phase       <= P_WAIT_EMPTY;
            busy        <= 1'b0;
            tx_enable   <= 1'b0;
            ack_timeout <= 1'b1;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          phase     <= P_WAIT_EMPTY;
          busy      <= 1'b0;
          tx_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_frame_tx.sv
// Directed bench for msg_frame_tx: a vector table of frame lengths plus hand-written
// sequences for timeout, stalled UART, mid-frame writes/sends and reset during BODY.
module tb_msg_frame_tx;

  localparam int DMAX   = 10;
  localparam int ACK_TO = 100;

  logic       ct_rxclk = 1'b0;
  logic       reset    = 1'b0;
  logic       wr_en    = 1'b0;
  logic [3:0] wr_addr  = 4'h0;
  logic [7:0] wr_data  = 8'h00;
  logic       send     = 1'b0;
  logic [7:0] send_len = 8'h00;
  logic       tx_empty = 1'b1;
  logic [8:0] tx_data;
  logic       ld_tx_data, tx_enable, busy, done, len_clamped, ack_timeout;

  msg_frame_tx #(.DATAMAXBYTES(DMAX), .SP_START(8'h7E), .SP_END(8'h7D), .ACK_TIMEOUT(ACK_TO)) dut (
    .ct_rxclk(ct_rxclk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .send(send), .send_len(send_len), .tx_empty(tx_empty), .tx_data(tx_data),
    .ld_tx_data(ld_tx_data), .tx_enable(tx_enable), .busy(busy), .done(done),
    .len_clamped(len_clamped), .ack_timeout(ack_timeout)
  );

  always #5 ct_rxclk = ~ct_rxclk;

  int         errors = 0;
  int         checks = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         done_cnt = 0;
  int         mode = 0;   // 0: prompt UART, 1: never accepts, 2: holds tx_empty low
  logic       ld_d = 1'b0;
  logic [7:0] model_buf [DMAX];

  typedef struct {
    logic [7:0] send_len;
    logic       exp_clamp;
    int         exp_len;
  } vec_t;
  vec_t vecs [6];

  // UART model: tx_empty drops one cycle after a load, returns high the cycle after.
  always @(negedge ct_rxclk) begin
    case (mode)
      0: begin tx_empty = !ld_d; ld_d = ld_tx_data; end
      1: begin tx_empty = 1'b1;  ld_d = 1'b0; end
      default: begin tx_empty = 1'b0; ld_d = 1'b0; end
    endcase
  end

  always @(negedge ct_rxclk) begin
    if (ld_tx_data) got_q.push_back(tx_data);
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic write_byte(input logic [3:0] a, input logic [7:0] d);
    @(negedge ct_rxclk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge ct_rxclk);
    wr_en = 1'b0;
    if (int'(a) < DMAX) model_buf[a] = d;
  endtask

  task automatic build_exp(input int n);
    exp_q.delete();
    exp_q.push_back(9'h17E);
    exp_q.push_back({1'b0, 8'(n)});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, model_buf[i]});
    exp_q.push_back(9'h17D);
  endtask

  task automatic compare_stream(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check({name, "_sym"}, got_q[i], exp_q[i]);
  endtask

  task automatic run_frame(input string name, input logic [7:0] slen, input logic exp_clamp,
                           input int exp_len);
    int gap;
    bit seen;
    build_exp(exp_len);
    got_q.delete();
    done_cnt = 0;
    @(negedge ct_rxclk);
    send = 1'b1; send_len = slen;
    @(negedge ct_rxclk);
    send = 1'b0;
    check({name, "_busy_rise"}, busy, 1'b1);
    check({name, "_tx_enable"}, tx_enable, 1'b1);
    check({name, "_len_clamped"}, len_clamped, exp_clamp);
    check({name, "_ack_timeout_clr"}, ack_timeout, 1'b0);
    gap = 0;
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge ct_rxclk);
      if (done) seen = 1;
      else if (!busy) gap++;
    end
    check({name, "_done_seen"}, seen, 1'b1);
    check({name, "_busy_gap"}, gap, 0);
    check({name, "_busy_fall"}, busy, 1'b0);
    @(negedge ct_rxclk);
    check({name, "_done_once"}, done_cnt, 1);
    compare_stream(name);
  endtask

  initial begin
    int ld_cyc, fell, snap;
    bit seen;

    vecs[0] = '{8'd3,  1'b0, 3};
    vecs[1] = '{8'd0,  1'b0, 0};
    vecs[2] = '{8'd15, 1'b1, 10};
    vecs[3] = '{8'd10, 1'b0, 10};
    vecs[4] = '{8'd11, 1'b1, 10};
    vecs[5] = '{8'd1,  1'b0, 1};
    for (int i = 0; i < DMAX; i++) model_buf[i] = 8'h00;

    repeat (3) @(negedge ct_rxclk);
    check("reset_outputs", {tx_data, ld_tx_data, tx_enable, busy, done, len_clamped, ack_timeout}, 0);
    reset = 1'b1;

    write_byte(4'd0, 8'h11);
    write_byte(4'd1, 8'h7E);
    write_byte(4'd2, 8'h33);
    for (int i = 3; i < DMAX; i++) write_byte(4'(i), 8'hA0 + 8'(i));
    for (int i = DMAX; i < 16; i++) write_byte(4'(i), 8'hEE);

    for (int v = 0; v < 6; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].send_len, vecs[v].exp_clamp, vecs[v].exp_len);

    // UART never accepts: single load, abort after ACK_TO cycles of tx_empty high.
    mode = 1;
    got_q.delete();
    done_cnt = 0;
    @(negedge ct_rxclk);
    send = 1'b1; send_len = 8'd3;
    @(negedge ct_rxclk);
    send = 1'b0;
    ld_cyc = -1;
    fell = -1;
    for (int c = 0; c < 400 && fell < 0; c++) begin
      @(negedge ct_rxclk);
      if (ld_tx_data && ld_cyc < 0) ld_cyc = c;
      if (!busy) fell = c;
    end
    check("timeout_window", fell - ld_cyc, ACK_TO);
    check("timeout_flag", ack_timeout, 1'b1);
    check("timeout_tx_enable", tx_enable, 1'b0);
    repeat (3) @(negedge ct_rxclk);
    check("timeout_no_done", done_cnt, 0);
    check("timeout_one_load", got_q.size(), 1);
    check("timeout_tx_data_held", tx_data, 9'h17E);
    mode = 0;
    run_frame("after_timeout", 8'd3, 1'b0, 3);

    // tx_empty held low: no load, no timeout; mid-frame writes and sends are ignored.
    mode = 2;
    repeat (500) @(negedge ct_rxclk);
    build_exp(3);
    got_q.delete();
    done_cnt = 0;
    @(negedge ct_rxclk);
    send = 1'b1; send_len = 8'd3;
    @(negedge ct_rxclk);
    send = 1'b0;
    @(negedge ct_rxclk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h99; send = 1'b1; send_len = 8'd1;
    @(negedge ct_rxclk);
    wr_en = 1'b0; send = 1'b0;
    repeat (500) @(negedge ct_rxclk);
    check("stall_no_load", got_q.size(), 0);
    check("stall_busy", busy, 1'b1);
    check("stall_no_timeout", ack_timeout, 1'b0);
    mode = 0;
    seen = 0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge ct_rxclk);
      if (c == 6) begin wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h55; send = 1'b1; send_len = 8'd0; end
      if (c == 7) begin wr_en = 1'b0; send = 1'b0; end
      if (done) seen = 1;
    end
    check("stall_done_seen", seen, 1'b1);
    repeat (6) @(negedge ct_rxclk);
    check("stall_done_once", done_cnt, 1);
    check("stall_no_restart", busy, 1'b0);
    compare_stream("stall");

    // Reset during BODY aborts at once and clears the payload buffer.
    got_q.delete();
    @(negedge ct_rxclk);
    send = 1'b1; send_len = 8'd10;
    @(negedge ct_rxclk);
    send = 1'b0;
    for (int c = 0; c < 300 && got_q.size() < 5; c++) @(negedge ct_rxclk);
    check("body_reached", got_q.size() >= 5, 1'b1);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs",
             {tx_data, ld_tx_data, tx_enable, busy, done, len_clamped, ack_timeout}, 0);
    snap = got_q.size();
    repeat (3) @(negedge ct_rxclk);
    check("reset_no_load", got_q.size(), snap);
    reset = 1'b1;
    for (int i = 0; i < DMAX; i++) model_buf[i] = 8'h00;
    run_frame("post_reset", 8'd1, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
